cnn_input_streamer: RTL and testbench

Transmitter for the CNN input port: holds one complete single-channel input feature map (F_IN_W × F_IN_H words) in an internal synchronous RAM, loaded word by word by a host. On `start_i` it replays the map in raster order over the CNN valid/ready/addr input interface, with a programmable idle gap after every transfer. It sits directly in front of `CNN_v2` and drives its `cnn_input_*` port, replacing host-side pixel feeding.

---
 rtl/cnn_input_streamer.sv | 176 +++++++++++++++++
 tb/tb_cnn_input_streamer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_input_streamer.sv
// Holds one host-loaded feature map in a synchronous RAM and replays it in
// raster order over the CNN valid/ready/addr input port, with an idle gap after every word.
module cnn_input_streamer #(
  parameter int FEATURE_MAP_RESOLUTION = 16,
  parameter int FEATURE_MAP_ADDRWIDE   = 10,
  parameter int F_IN_W                 = 29,
  parameter int F_IN_H                 = 29,
  parameter int GAP_CYCLES             = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              load_valid_i,
  input  logic [FEATURE_MAP_ADDRWIDE-1:0]   load_addr_i,
  input  logic [FEATURE_MAP_RESOLUTION-1:0] load_data_i,
  output logic                              load_ready_o,
  input  logic                              start_i,
  input  logic                              abort_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              cnn_input_valid_o,
  output logic [FEATURE_MAP_RESOLUTION-1:0] cnn_input_data_o,
  output logic [FEATURE_MAP_ADDRWIDE-1:0]   cnn_input_addr_o,
  input  logic                              cnn_input_ready_i,
  output logic [1:0]                        dbg_state_o
);

  localparam int W     = FEATURE_MAP_RESOLUTION;
  localparam int AW    = FEATURE_MAP_ADDRWIDE;
  localparam int N     = F_IN_W * F_IN_H;
  localparam int DEPTH = 1 << AW;
  localparam int GW    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [AW:0]   N_EXT    = (AW+1)'(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 1) ? GW'(GAP_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Valid/ready: a word moves only on a rising edge where valid and ready are
  // both high; once valid rises, data and addr hold until that edge, and valid
  // falls without a transfer only on abort or reset.

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    rd_data_q;

  logic [W-1:0]    mem [DEPTH];
  logic            mem_we;
  logic            mem_re;
  logic            xfer;

  assign xfer   = valid_q && cnn_input_ready_i;
  assign mem_we = (state_q == ST_IDLE) && load_valid_i && ({1'b0, load_addr_i} < N_EXT);
  assign mem_re = (state_q == ST_FETCH);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
          ptr_d   = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_SEND;
        valid_d = 1'b1;
        addr_d  = ptr_q;
      end
      ST_SEND: begin
        if (xfer) begin
          valid_d = 1'b0;
          if (ptr_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
            // The fetch itself fills the last idle cycle, so GAP covers the rest.
            if (GAP_CYCLES > 1) begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LOAD;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_FETCH;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gap_cnt_q <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Frame buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (mem_re) begin
      rd_data_q <= mem[ptr_q];
    end
  end

  assign load_ready_o      = (state_q == ST_IDLE);
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign cnn_input_valid_o = valid_q;
  assign cnn_input_data_o  = rd_data_q;
  assign cnn_input_addr_o  = addr_q;
  assign dbg_state_o       = state_q;

  a_hold_until_xfer: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnn_input_valid_o && !cnn_input_ready_i && !abort_i) |=>
      (cnn_input_valid_o && $stable(cnn_input_data_o) && $stable(cnn_input_addr_o)));

  a_done_in_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_o |-> (!busy_o && load_ready_o));

endmodule

// File: tb/tb_cnn_input_streamer.sv
// Directed bench for cnn_input_streamer: cycle table for the start/stall/abort
// path, then whole frames covering stall, dropped writes, abort and reset.
module tb_cnn_input_streamer;

  localparam int W   = 16;
  localparam int AW  = 10;
  localparam int FW  = 29;
  localparam int FH  = 29;
  localparam int GAP = 2;
  localparam int N   = FW * FH;

  logic          clk;
  logic          rst_n;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_data;
  logic          load_ready;
  logic          start;
  logic          abort;
  logic          busy;
  logic          done;
  logic          valid;
  logic [W-1:0]  data;
  logic [AW-1:0] addr;
  logic          ready;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [AW+W-1:0] exp_q[$];
  logic [W-1:0]    model_mem [N];

  typedef struct {
    logic          start;
    logic          abort;
    logic          ready;
    logic          exp_valid;
    logic          exp_busy;
    logic          exp_done;
    logic          exp_lr;
    logic          chk_word;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_data;
  } vec_t;

  vec_t vecs [9];

  cnn_input_streamer #(
    .FEATURE_MAP_RESOLUTION(W),
    .FEATURE_MAP_ADDRWIDE  (AW),
    .F_IN_W                (FW),
    .F_IN_H                (FH),
    .GAP_CYCLES            (GAP)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .load_valid_i     (load_valid),
    .load_addr_i      (load_addr),
    .load_data_i      (load_data),
    .load_ready_o     (load_ready),
    .start_i          (start),
    .abort_i          (abort),
    .busy_o           (busy),
    .done_o           (done),
    .cnn_input_valid_o(valid),
    .cnn_input_data_o (data),
    .cnn_input_addr_o (addr),
    .cnn_input_ready_i(ready),
    .dbg_state_o      (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every accepted word must match the head of exp_q
  always @(posedge clk) begin
    logic [AW+W-1:0] exp_w;
    if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL xfer_extra: got addr=%0d data=0x%0h, required no transfer", addr, data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({addr, data} !== exp_w) begin
          n_errors++;
          $display("FAIL xfer_word: got addr=%0d data=0x%0h, required addr=%0d data=0x%0h",
                   addr, data, exp_w[AW+W-1:W], exp_w[W-1:0]);
        end
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_word(input int a, input logic [W-1:0] d);
    load_valid = 1'b1;
    load_addr  = AW'(a);
    load_data  = d;
    step();
    load_valid = 1'b0;
    if (a < N) model_mem[a] = d;
  endtask

  task automatic push_frame(input int count);
    for (int i = 0; i < count; i++) exp_q.push_back({AW'(i), model_mem[i]});
  endtask

  task automatic wait_addr(input int a, input string nm);
    int k;
    k = 0;
    while (!(valid === 1'b1 && addr == AW'(a)) && k < 5000) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= 5000) begin
      n_errors++;
      $display("FAIL %s: got no valid word at addr %0d in 5000 cycles, required one", nm, a);
    end
  endtask

  task automatic run_to_done(input string nm);
    int k;
    k = 0;
    while (done !== 1'b1 && k < 4 * N) begin
      step();
      k++;
    end
    check(nm, 32'(done), 32'd1);
  endtask

  function automatic vec_t mk(input logic s, input logic a, input logic r,
                              input logic ev, input logic eb, input logic ed,
                              input logic el, input logic cw,
                              input logic [AW-1:0] ea, input logic [W-1:0] edt);
    vec_t v;
    v.start = s; v.abort = a; v.ready = r;
    v.exp_valid = ev; v.exp_busy = eb; v.exp_done = ed; v.exp_lr = el;
    v.chk_word = cw; v.exp_addr = ea; v.exp_data = edt;
    return v;
  endfunction

  initial begin
    int first_k, last_k, done_k, vcnt, cad_err, dc;

    //          start abort ready | valid busy done lr | word addr data
    vecs[0] = mk(1'b0, 1'b1, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 16'd0);
    vecs[1] = mk(1'b1, 1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    vecs[2] = mk(1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 16'd100);
    vecs[3] = mk(1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd0, 16'd100);
    vecs[4] = mk(1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    vecs[5] = mk(1'b0, 1'b0, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 16'd0);
    vecs[6] = mk(1'b0, 1'b0, 1'b1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'd1, 16'd101);
    vecs[7] = mk(1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 16'd0);
    vecs[8] = mk(1'b0, 1'b0, 1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 16'd0);

    rst_n = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; abort = 1'b0; ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);

    for (int i = 0; i < N; i++) load_word(i, W'(i + 100));

    // Cycle table: start, two-cycle stall on word 0, word 1, abort
    exp_q.push_back({AW'(0), 16'd100});
    for (int i = 0; i < 9; i++) begin
      start = vecs[i].start;
      abort = vecs[i].abort;
      ready = vecs[i].ready;
      step();
      start = 1'b0;
      abort = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d_load_ready", i), 32'(load_ready), 32'(vecs[i].exp_lr));
      if (vecs[i].chk_word) begin
        check($sformatf("vec%0d_addr", i), 32'(addr), 32'(vecs[i].exp_addr));
        check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      end
    end
    check("vec_sb_empty", 32'(exp_q.size()), 32'd0);

    // Frame 1: full frame, ready high, cadence and duration
    push_frame(N);
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("f1_busy_after_start", 32'(busy), 32'd1);
    check("f1_valid_in_fetch", 32'(valid), 32'd0);
    first_k = -1; last_k = -1; done_k = -1; vcnt = 0; cad_err = 0;
    for (int k = 1; k <= 4 * N && done_k < 0; k++) begin
      step();
      if (valid === 1'b1) begin
        if (first_k < 0) first_k = k;
        else if (k - last_k != GAP + 1) cad_err++;
        last_k = k;
        vcnt++;
      end
      if (done === 1'b1) done_k = k;
    end
    check("f1_first_valid_latency", 32'(first_k), 32'd1);
    check("f1_frame_duration", 32'(done_k - first_k), 32'(N * (GAP + 1) - GAP));
    check("f1_valid_count", 32'(vcnt), 32'(N));
    check("f1_cadence_errors", 32'(cad_err), 32'd0);
    check("f1_done_busy", 32'(busy), 32'd0);
    check("f1_done_load_ready", 32'(load_ready), 32'd1);
    check("f1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Frame 2: start together with a write to word 0, in the done cycle
    model_mem[0] = 16'h5A5A;
    push_frame(N);
    load_valid = 1'b1; load_addr = '0; load_data = 16'h5A5A;
    start = 1'b1;
    step();
    load_valid = 1'b0;
    start = 1'b0;
    check("f1_done_single_pulse", 32'(done), 32'd0);
    check("f2_restart_at_done", 32'(busy), 32'd1);

    wait_addr(3, "f2_wait_word3");
    load_valid = 1'b1; load_addr = 10'd3; load_data = 16'hFFFF;
    start = 1'b1;
    check("f2_load_ready_busy", 32'(load_ready), 32'd0);
    step();
    load_valid = 1'b0;
    start = 1'b0;
    check("f2_busy_after_poke", 32'(busy), 32'd1);

    wait_addr(7, "f2_wait_word7");
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("f2_stall%0d_valid", i), 32'(valid), 32'd1);
      check($sformatf("f2_stall%0d_addr", i), 32'(addr), 32'd7);
      check($sformatf("f2_stall%0d_data", i), 32'(data), 32'd107);
    end
    ready = 1'b1;
    step();
    check("f2_gap1_valid", 32'(valid), 32'd0);
    step();
    check("f2_gap2_valid", 32'(valid), 32'd0);
    step();
    check("f2_word8_valid", 32'(valid), 32'd1);
    check("f2_word8_addr", 32'(addr), 32'd8);
    run_to_done("f2_done");
    check("f2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Frame 3: abort while word 400 is offered
    push_frame(400);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_addr(400, "f3_wait_word400");
    ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("f3_abort_valid", 32'(valid), 32'd0);
    check("f3_abort_busy", 32'(busy), 32'd0);
    check("f3_abort_done", 32'(done), 32'd0);
    check("f3_abort_load_ready", 32'(load_ready), 32'd1);
    dc = done_cnt;
    step();
    step();
    step();
    check("f3_no_done_after_abort", 32'(done_cnt), 32'(dc));
    check("f3_sb_empty", 32'(exp_q.size()), 32'd0);

    // Frame 4: replays from word 0, then reset while word 200 is offered
    ready = 1'b1;
    push_frame(200);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_addr(200, "f4_wait_word200");
    ready = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("f4_rst_valid", 32'(valid), 32'd0);
    check("f4_rst_data", 32'(data), 32'd0);
    check("f4_rst_addr", 32'(addr), 32'd0);
    check("f4_rst_busy", 32'(busy), 32'd0);
    check("f4_rst_done", 32'(done), 32'd0);
    check("f4_rst_load_ready", 32'(load_ready), 32'd1);
    check("f4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Frame 5: RAM contents survive abort and reset
    ready = 1'b1;
    push_frame(N);
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("f5_done");
    step();
    check("f5_done_single_pulse", 32'(done), 32'd0);
    check("f5_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
